// File: rtl/icache_responder_if.sv
// Fetch-side bus bundle for icache_responder.
// Datapath request/response plus memory-controller read port.
interface icache_responder_if #(
  parameter int PC_WIDTH = 32
);
  logic                imemREN;
  logic [PC_WIDTH-1:0] imemaddr;
  logic                ihit;
  logic [PC_WIDTH-1:0] imemload;
  logic                iREN;
  logic [PC_WIDTH-1:0] iaddr;
  logic                iwait;
  logic [PC_WIDTH-1:0] iload;

  modport slave (
    input  imemREN,
    input  imemaddr,
    input  iwait,
    input  iload,
    output ihit,
    output imemload,
    output iREN,
    output iaddr
  );

  modport master (
    output imemREN,
    output imemaddr,
    output iwait,
    output iload,
    input  ihit,
    input  imemload,
    input  iREN,
    input  iaddr
  );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped 2-word-block read-only instruction cache.
// Optional hit/miss counters when ICACHE_STATS_EN is defined.
module icache_responder #(
  parameter int SETS     = 8,
  parameter int PC_WIDTH = 32
) (
  input  logic CLK,
  input  logic nRST,
  icache_responder_if.slave bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = PC_WIDTH - IDX_W - 3;

  typedef enum logic [1:0] {
    IDLE,
    FETCH0,
    FETCH1
  } state_t;

  state_t state, next_state;

  logic [SETS-1:0]     valid;
  logic [TAG_W-1:0]    tags  [SETS];
  logic [PC_WIDTH-1:0] word0 [SETS];
  logic [PC_WIDTH-1:0] word1 [SETS];
  logic [PC_WIDTH-1:0] maddr;

  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] midx;
  logic [TAG_W-1:0] tag;
  logic [TAG_W-1:0] mtag;
  logic             hit;
  logic             miss;
  logic             fill0;
  logic             fill1;
  logic             unused_bits;

  assign idx  = bus.imemaddr[IDX_W+2:3];
  assign tag  = bus.imemaddr[PC_WIDTH-1:IDX_W+3];
  assign midx = maddr[IDX_W+2:3];
  assign mtag = maddr[PC_WIDTH-1:IDX_W+3];

  // Byte offset is ignored; the fill address is always block aligned.
  assign unused_bits = ^{bus.imemaddr[1:0], maddr[2:0]};

  // Lookup is only meaningful in IDLE; a frame being refilled never hits.
  assign hit   = (state == IDLE) && bus.imemREN
               && valid[idx] && (tags[idx] == tag);
  assign miss  = (state == IDLE) && bus.imemREN && !hit;
  assign fill0 = (state == FETCH0) && !bus.iwait;
  assign fill1 = (state == FETCH1) && !bus.iwait;

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic: miss -> two word reads -> back to lookup.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (miss)  next_state = FETCH0;
      FETCH0:  if (fill0) next_state = FETCH1;
      FETCH1:  if (fill1) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs: combinational hit in IDLE, memory requests in FETCH states.
  always_comb begin
    bus.ihit     = 1'b0;
    bus.imemload = '0;
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    unique case (state)
      IDLE: begin
        bus.ihit = hit;
        if (hit)
          bus.imemload = bus.imemaddr[2] ? word1[idx]
                                         : word0[idx];
      end
      FETCH0: begin
        bus.iREN  = 1'b1;
        bus.iaddr = {maddr[PC_WIDTH-1:3], 3'b000};
      end
      FETCH1: begin
        bus.iREN  = 1'b1;
        bus.iaddr = {maddr[PC_WIDTH-1:3], 3'b100};
      end
      default: ;
    endcase
  end

  // Miss address is held for the whole fill, even if the PC redirects.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)     maddr <= '0;
    else if (miss) maddr <= bus.imemaddr;
  end

  // Valid bits: set when the second word lands; a conflict keeps it set.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)      valid       <= '0;
    else if (fill1) valid[midx] <= 1'b1;
  end

  // Tag and data arrays carry no reset.
  always_ff @(posedge CLK) begin
    if (fill0) word0[midx] <= bus.iload;
    if (fill1) begin
      word1[midx] <= bus.iload;
      tags[midx]  <= mtag;
    end
  end

`ifdef ICACHE_STATS_EN
  // Free-running hit/miss counters, wrapping naturally.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (bus.ihit) hit_count  <= hit_count + 32'd1;
      if (miss)     miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder.
// Reference cache model tracks frame tags; memory is a fixed function.
module tb_icache_responder;

  localparam int SETS = 8;

  logic CLK;
  logic nRST;
  int   wait_n;
  int   wcnt;
  int   n_checks;
  int   n_fail;
  int   exp_hits;
  int   exp_misses;

  bit          m_valid [SETS];
  int unsigned m_tag   [SETS];

  logic        tr_ren  [$];
  logic [31:0] tr_addr [$];

  icache_responder_if #(.PC_WIDTH(32)) bus ();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache_responder #(
    .SETS(SETS),
    .PC_WIDTH(32)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .bus(bus.slave)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    case (w)
      32'h0000_0000: return 32'h1111_1111;
      32'h0000_0004: return 32'h2222_2222;
      32'h0000_0040: return 32'hAAAA_AAAA;
      32'h0000_0044: return 32'hBBBB_BBBB;
      default:       return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  // Memory: wait_n busy cycles before each word, then data.
  assign bus.iwait = bus.iREN && (wcnt < wait_n);
  assign bus.iload = mem_val(bus.iaddr);

  always @(posedge CLK or negedge nRST) begin
    if (!nRST)                     wcnt <= 0;
    else if (bus.iREN && bus.iwait) wcnt <= wcnt + 1;
    else                           wcnt <= 0;
  end

  function automatic bit model_access(input logic [31:0] a);
    int unsigned blk;
    int unsigned ix;
    int unsigned tg;
    bit          h;
    blk = a / 8;
    ix  = blk % SETS;
    tg  = blk / SETS;
    h   = m_valid[ix] && (m_tag[ix] == tg);
    m_valid[ix] = 1'b1;
    m_tag[ix]   = tg;
    exp_hits    = exp_hits + 1;
    if (!h) exp_misses = exp_misses + 1;
    return h;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
  endfunction

  // Issues one fetch; returns the cycle of the hit (-1 on timeout).
  task automatic run_access(input logic [31:0] a,
                            output int cyc,
                            output logic [31:0] data);
    tr_ren.delete();
    tr_addr.delete();
    bus.imemaddr = a;
    bus.imemREN  = 1'b1;
    cyc  = -1;
    data = 'x;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      tr_ren.push_back(bus.iREN);
      tr_addr.push_back(bus.iaddr);
      if (bus.ihit) begin
        cyc  = k;
        data = bus.imemload;
        break;
      end
      @(posedge CLK);
      #1;
    end
    if (cyc >= 0) begin
      @(posedge CLK);
      #1;
    end
    bus.imemREN = 1'b0;
  endtask

  task automatic test_reset();
    nRST         = 1'b0;
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0;
    wait_n       = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    n_checks++;
    if (bus.ihit !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ihit: got %b want 0", bus.ihit);
    end
    n_checks++;
    if (bus.iREN !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_iREN: got %b want 0", bus.iREN);
    end
    n_checks++;
    if (bus.iaddr !== 32'h0 || bus.imemload !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_bus: iaddr %h imemload %h want 0",
               bus.iaddr, bus.imemload);
    end
`ifdef ICACHE_STATS_EN
    n_checks++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_stats: hit %0d miss %0d want 0",
               hit_count, miss_count);
    end
`endif
    @(posedge CLK);
    #1;
    bus.imemREN = 1'b0;
    nRST        = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_cold_miss();
    int          cyc;
    logic [31:0] d;
    logic [31:0] ea;
    void'(model_access(32'h0));
    run_access(32'h0, cyc, d);
    n_checks++;
    if (cyc !== 3) begin
      n_fail++;
      $display("FAIL cold_latency: got %0d want 3", cyc);
    end
    n_checks++;
    if (d !== 32'h1111_1111) begin
      n_fail++;
      $display("FAIL cold_data: got %h want 11111111", d);
    end
    n_checks++;
    if (tr_ren.size() < 3 || tr_ren[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL cold_idle_ren: trace too short or iREN set");
    end
    for (int k = 1; k < 3 && k < tr_addr.size(); k++) begin
      ea = (k == 1) ? 32'h0 : 32'h4;
      n_checks++;
      if (tr_ren[k] !== 1'b1 || tr_addr[k] !== ea) begin
        n_fail++;
        $display("FAIL cold_iaddr[%0d]: got %b/%h want 1/%h",
                 k, tr_ren[k], tr_addr[k], ea);
      end
    end
  endtask

  task automatic test_hit_same_block();
    int          cyc;
    logic [31:0] d;
    void'(model_access(32'h4));
    run_access(32'h4, cyc, d);
    n_checks++;
    if (cyc !== 0 || d !== 32'h2222_2222) begin
      n_fail++;
      $display("FAIL same_block_hit: cyc %0d data %h want 0/22222222",
               cyc, d);
    end
    n_checks++;
    if (tr_ren.size() < 1 || tr_ren[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL same_block_ren: iREN asserted on a hit");
    end
  endtask

  task automatic test_conflict();
    int          cyc;
    logic [31:0] d;
    void'(model_access(32'h40));
    run_access(32'h40, cyc, d);
    n_checks++;
    if (cyc !== 3 || d !== 32'hAAAA_AAAA) begin
      n_fail++;
      $display("FAIL conflict_fill: cyc %0d data %h want 3/aaaaaaaa",
               cyc, d);
    end
    void'(model_access(32'h40));
    run_access(32'h40, cyc, d);
    n_checks++;
    if (cyc !== 0 || d !== 32'hAAAA_AAAA) begin
      n_fail++;
      $display("FAIL conflict_hit: cyc %0d data %h want 0/aaaaaaaa",
               cyc, d);
    end
    void'(model_access(32'h0));
    run_access(32'h0, cyc, d);
    n_checks++;
    if (cyc !== 3 || d !== 32'h1111_1111) begin
      n_fail++;
      $display("FAIL conflict_evict: cyc %0d data %h want 3/11111111",
               cyc, d);
    end
  endtask

  task automatic test_wait_states();
    int          cyc;
    logic [31:0] d;
    logic [31:0] ea;
    wait_n = 5;
    void'(model_access(32'h8));
    run_access(32'h8, cyc, d);
    n_checks++;
    if (cyc !== 13 || d !== mem_val(32'h8)) begin
      n_fail++;
      $display("FAIL wait_fill: cyc %0d data %h want 13/%h",
               cyc, d, mem_val(32'h8));
    end
    for (int k = 1; k < 13 && k < tr_addr.size(); k++) begin
      ea = (k <= 6) ? 32'h8 : 32'hC;
      n_checks++;
      if (tr_ren[k] !== 1'b1 || tr_addr[k] !== ea) begin
        n_fail++;
        $display("FAIL wait_iaddr[%0d]: got %b/%h want 1/%h",
                 k, tr_ren[k], tr_addr[k], ea);
      end
    end
    wait_n = 0;
    void'(model_access(32'h8));
    run_access(32'h8, cyc, d);
    n_checks++;
    if (cyc !== 0 || d !== mem_val(32'h8)) begin
      n_fail++;
      $display("FAIL wait_hit: cyc %0d data %h", cyc, d);
    end
  endtask

  task automatic test_redirect();
    int          cyc;
    logic [31:0] d;
    logic [31:0] a4;
    void'(model_access(32'h10));
    void'(model_access(32'h20));
    exp_hits     = exp_hits - 1;
    bus.imemaddr = 32'h10;
    bus.imemREN  = 1'b1;
    cyc = -1;
    d   = 'x;
    a4  = 'x;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (k == 4) a4 = bus.iaddr;
      if (bus.ihit) begin
        cyc = k;
        d   = bus.imemload;
        break;
      end
      @(posedge CLK);
      #1;
      if (k == 1) bus.imemaddr = 32'h20;
    end
    if (cyc >= 0) begin
      @(posedge CLK);
      #1;
    end
    bus.imemREN = 1'b0;
    n_checks++;
    if (cyc !== 6 || d !== mem_val(32'h20)) begin
      n_fail++;
      $display("FAIL redirect_fill: cyc %0d data %h want 6/%h",
               cyc, d, mem_val(32'h20));
    end
    n_checks++;
    if (a4 !== 32'h20) begin
      n_fail++;
      $display("FAIL redirect_iaddr: got %h want 00000020", a4);
    end
    void'(model_access(32'h10));
    run_access(32'h10, cyc, d);
    n_checks++;
    if (cyc !== 0 || d !== mem_val(32'h10)) begin
      n_fail++;
      $display("FAIL redirect_old_hit: cyc %0d data %h", cyc, d);
    end
  endtask

  task automatic test_reset_mid_fill();
    int          cyc;
    logic [31:0] d;
    wait_n       = 5;
    bus.imemaddr = 32'h48;
    bus.imemREN  = 1'b1;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    n_checks++;
    if (bus.iREN !== 1'b1) begin
      n_fail++;
      $display("FAIL midfill_fetch: iREN %b want 1", bus.iREN);
    end
    #2;
    nRST = 1'b0;
    #1;
    n_checks++;
    if (bus.iREN !== 1'b0 || bus.ihit !== 1'b0) begin
      n_fail++;
      $display("FAIL midfill_async: iREN %b ihit %b want 0/0",
               bus.iREN, bus.ihit);
    end
    bus.imemREN = 1'b0;
    @(posedge CLK);
    #1;
    model_reset();
    wait_n = 0;
`ifdef ICACHE_STATS_EN
    n_checks++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      n_fail++;
      $display("FAIL midfill_stats: hit %0d miss %0d want 0",
               hit_count, miss_count);
    end
`endif
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    void'(model_access(32'h0));
    run_access(32'h0, cyc, d);
    n_checks++;
    if (cyc !== 3 || d !== 32'h1111_1111) begin
      n_fail++;
      $display("FAIL midfill_invalid: cyc %0d data %h want 3/11111111",
               cyc, d);
    end
  endtask

  task automatic test_random();
    int          cyc;
    int          ecyc;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] base;
    logic [31:0] ea;
    bit          h;
    for (int n = 0; n < 40; n++) begin
      wait_n = $urandom_range(0, 2);
      a      = 32'($urandom_range(0, 511));
      h      = model_access(a);
      ecyc   = h ? 0 : 3 + 2 * wait_n;
      base   = {a[31:3], 3'b000};
      run_access(a, cyc, d);
      n_checks++;
      if (cyc !== ecyc || d !== mem_val(a)) begin
        n_fail++;
        $display("FAIL rand[%0d] a=%h: cyc %0d data %h want %0d/%h",
                 n, a, cyc, d, ecyc, mem_val(a));
      end
      for (int k = 1; k < ecyc && k < tr_addr.size(); k++) begin
        ea = (k <= 1 + wait_n) ? base : base + 32'd4;
        n_checks++;
        if (tr_ren[k] !== 1'b1 || tr_addr[k] !== ea) begin
          n_fail++;
          $display("FAIL rand[%0d]_iaddr[%0d]: got %b/%h want 1/%h",
                   n, k, tr_ren[k], tr_addr[k], ea);
        end
      end
    end
    wait_n = 0;
  endtask

  task automatic test_stats();
`ifdef ICACHE_STATS_EN
    n_checks++;
    if (hit_count !== 32'(exp_hits)
        || miss_count !== 32'(exp_misses)) begin
      n_fail++;
      $display("FAIL stats: hit %0d miss %0d want %0d/%0d",
               hit_count, miss_count, exp_hits, exp_misses);
    end
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_cold_miss();
    test_hit_same_block();
    test_conflict();
    test_wait_states();
    test_redirect();
    test_stats();
    test_reset_mid_fill();
    test_random();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
